// File: rtl/dx_operand_stage_pkg.sv
// Shared definitions for the decode/execute operand stage: default widths,
// ALU opcode values and the D/X register state encoding.
package dx_operand_stage_pkg;

    localparam int DX_DW  = 32;
    localparam int DX_RW  = 5;
    localparam int DX_IW  = 17;
    localparam int DX_SCW = 16;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLL = 5'd4;
    localparam logic [4:0] ALU_SRA = 5'd5;

    typedef enum logic [1:0] {
        DX_EMPTY  = 2'd0,
        DX_FULL   = 2'd1,
        DX_HAZARD = 2'd2
    } dx_state_t;

endpackage

// File: rtl/dx_operand_stage_bypass_mux.sv
// Single-operand forward select: register 0, then X/M (non-load), then M/W,
// then the register-file value captured with the instruction.
module dx_bypass_mux #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] idx,
    input  logic [DW-1:0] reg_val,
    input  logic          xm_valid,
    input  logic          xm_is_load,
    input  logic [RW-1:0] xm_rd,
    input  logic [DW-1:0] xm_val,
    input  logic          mw_valid,
    input  logic [RW-1:0] mw_rd,
    input  logic [DW-1:0] mw_val,
    output logic [DW-1:0] val
);

    always_comb begin
        val = reg_val;
        if (idx == '0) begin
            val = '0;
        end else if (xm_valid && !xm_is_load && (xm_rd == idx)) begin
            val = xm_val;
        end else if (mw_valid && (mw_rd == idx)) begin
            val = mw_val;
        end
    end

endmodule

// File: rtl/dx_operand_stage.sv
// D/X pipeline register with operand bypass and load-use interlock; presents
// forwarded operands, opcode and shift amount to the ALU.
module dx_operand_stage
    import dx_operand_stage_pkg::*;
#(
    parameter int DW  = DX_DW,
    parameter int RW  = DX_RW,
    parameter int IW  = DX_IW,
    parameter int SCW = DX_SCW
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4:0]     in_aluop,
    input  logic [4:0]     in_shamt,
    input  logic [RW-1:0]  in_rs,
    input  logic [RW-1:0]  in_rt,
    input  logic [DW-1:0]  in_rs_val,
    input  logic [DW-1:0]  in_rt_val,
    input  logic           in_rt_used,
    input  logic           in_use_imm,
    input  logic [IW-1:0]  in_imm,
    input  logic [RW-1:0]  in_rd,
    input  logic           xm_valid,
    input  logic [RW-1:0]  xm_rd,
    input  logic           xm_is_load,
    input  logic [DW-1:0]  xm_val,
    input  logic           mw_valid,
    input  logic [RW-1:0]  mw_rd,
    input  logic [DW-1:0]  mw_val,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  data_operandA,
    output logic [DW-1:0]  data_operandB,
    output logic [4:0]     ctrl_ALUopcode,
    output logic [4:0]     ctrl_shiftamt,
    output logic [RW-1:0]  out_rd,
    output logic [SCW-1:0] stall_count,
    output dx_state_t      dbg_state
);

    // Handshake: a transfer happens on a cycle where valid and ready are both
    // high at the rising edge; valid never depends on ready on the same side,
    // and a held instruction stays stable while out_valid & ~out_ready.

    dx_state_t     state, state_next;
    logic          dx_valid;
    logic          hz;
    logic          capture;

    logic [4:0]    h_aluop;
    logic [4:0]    h_shamt;
    logic [RW-1:0] h_rs;
    logic [RW-1:0] h_rt;
    logic [DW-1:0] h_rs_val;
    logic [DW-1:0] h_rt_val;
    logic          h_rt_used;
    logic          h_use_imm;
    logic [IW-1:0] h_imm;
    logic [RW-1:0] h_rd;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    assign dx_valid = (state != DX_EMPTY);

    // A load in X/M cannot be bypassed; wait until it reaches M/W.
    assign hz = dx_valid && xm_valid && xm_is_load && (xm_rd != '0) &&
                ((xm_rd == h_rs) || (h_rt_used && (xm_rd == h_rt)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DX_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DX_EMPTY: begin
                if (capture) state_next = DX_FULL;
            end
            DX_FULL, DX_HAZARD: begin
                if (flush || (out_valid && out_ready && !in_valid)) begin
                    state_next = DX_EMPTY;
                end else if (hz) begin
                    state_next = DX_HAZARD;
                end else begin
                    state_next = DX_FULL;
                end
            end
            default: state_next = DX_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = dx_valid && !hz && !flush;
        in_ready  = !flush && (!dx_valid || (out_valid && out_ready));
        capture   = in_valid && in_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_aluop     <= '0;
            h_shamt     <= '0;
            h_rs        <= '0;
            h_rt        <= '0;
            h_rs_val    <= '0;
            h_rt_val    <= '0;
            h_rt_used   <= 1'b0;
            h_use_imm   <= 1'b0;
            h_imm       <= '0;
            h_rd        <= '0;
            stall_count <= '0;
        end else begin
            if (capture) begin
                h_aluop   <= in_aluop;
                h_shamt   <= in_shamt;
                h_rs      <= in_rs;
                h_rt      <= in_rt;
                h_rs_val  <= in_rs_val;
                h_rt_val  <= in_rt_val;
                h_rt_used <= in_rt_used;
                h_use_imm <= in_use_imm;
                h_imm     <= in_imm;
                h_rd      <= in_rd;
            end
            if (hz && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    dx_bypass_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .idx        (h_rs),
        .reg_val    (h_rs_val),
        .xm_valid   (xm_valid),
        .xm_is_load (xm_is_load),
        .xm_rd      (xm_rd),
        .xm_val     (xm_val),
        .mw_valid   (mw_valid),
        .mw_rd      (mw_rd),
        .mw_val     (mw_val),
        .val        (fwd_rs)
    );

    dx_bypass_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .idx        (h_rt),
        .reg_val    (h_rt_val),
        .xm_valid   (xm_valid),
        .xm_is_load (xm_is_load),
        .xm_rd      (xm_rd),
        .xm_val     (xm_val),
        .mw_valid   (mw_valid),
        .mw_rd      (mw_rd),
        .mw_val     (mw_val),
        .val        (fwd_rt)
    );

    assign data_operandA  = fwd_rs;
    assign data_operandB  = h_use_imm ? {{(DW-IW){h_imm[IW-1]}}, h_imm} : fwd_rt;
    assign ctrl_ALUopcode = h_aluop;
    assign ctrl_shiftamt  = h_shamt;
    assign out_rd         = h_rd;
    assign dbg_state      = state;

endmodule
